// File: rtl/hue_pkg.sv
// Shared types and constants for the hue divider: function tags, sector
// offsets and the tag-to-offset helper used by the output stage.
package hue_pkg;

  typedef enum logic [1:0] {
    HUE_FN_RAW    = 2'd0,
    HUE_FN_SECT_R = 2'd1,
    HUE_FN_SECT_G = 2'd2,
    HUE_FN_SECT_B = 2'd3
  } hue_fn_t;

  localparam int HUE_SECT_R    = 0;
  localparam int HUE_SECT_G    = 2;
  localparam int HUE_SECT_B    = 4;
  localparam int HUE_SECT_SPAN = 6;

  // Sector offset in the quotient's fixed-point scale; RAW adds nothing.
  function automatic int hue_offset(hue_fn_t fn, int frac_w);
    case (fn)
      HUE_FN_SECT_R: return HUE_SECT_R << frac_w;
      HUE_FN_SECT_G: return HUE_SECT_G << frac_w;
      HUE_FN_SECT_B: return HUE_SECT_B << frac_w;
      default:       return 0;
    endcase
  endfunction

endpackage

// File: rtl/hue_div_stage.sv
// One restoring-division step: shift in the next numerator bit, trial-subtract
// the divisor, emit one quotient bit; sideband fields ride along unchanged.
module hue_div_stage
  import hue_pkg::*;
#(
  parameter int IN_W = 9,
  parameter int QW   = 17
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            en,
  input  logic [IN_W-1:0] rem,
  input  logic [QW-1:0]   nq,
  input  logic [IN_W-1:0] div,
  input  logic            sign,
  input  logic            dbz,
  input  hue_fn_t         fn,
  input  logic            valid,
  output logic [IN_W-1:0] rem_r,
  output logic [QW-1:0]   nq_r,
  output logic [IN_W-1:0] div_r,
  output logic            sign_r,
  output logic            dbz_r,
  output hue_fn_t         fn_r,
  output logic            valid_r
);

  logic [IN_W:0]   trial;
  logic [IN_W-1:0] diff;
  logic            ge;

  // nq holds the unconsumed numerator in its upper bits and the quotient
  // built so far in its lower bits; both shift left by one per stage.
  always_comb begin
    trial = {rem, nq[QW-1]};
    ge    = (trial >= {1'b0, div});
    diff  = trial[IN_W-1:0] - div;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the chain shifts by exactly one.
  always_ff @(posedge i_clk) begin
    if (i_rst) valid_r <= 1'b0;
    else if (en) valid_r <= valid;
  end

  // NOTE: datapath registers are deliberately not reset; only the valid bits
  // need a known value, and the payload is ignored while valid is low.
  always_ff @(posedge i_clk) begin
    if (en) begin
      rem_r  <= ge ? diff : trial[IN_W-1:0];
      nq_r   <= {nq[QW-2:0], ge};
      div_r  <= div;
      sign_r <= sign;
      dbz_r  <= dbz;
      fn_r   <= fn;
    end
  end

endmodule

// File: rtl/hue_div_pipe.sv
// Fully pipelined signed fixed-point divider with hue-sector offset, wrap,
// saturation and divide-by-zero flagging behind a global-stall handshake.
module hue_div_pipe
  import hue_pkg::*;
#(
  parameter int IN_W   = 9,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IN_W-1:0]  i_dividend,
  input  logic [IN_W-1:0]  i_divisor,
  input  logic [1:0]       i_function,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_dbz,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int QW         = IN_W + FRAC_W;
  localparam int LATENCY    = QW + 2;
  localparam int DIV_STAGES = LATENCY - 2;
  localparam int SUM_W      = ((QW + 1 > OUT_W) ? QW + 1 : OUT_W) + 3;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic en;
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  // Index 0 is the input register; index k is the output of division stage k.
  logic [IN_W-1:0] rem_p   [DIV_STAGES+1];
  logic [QW-1:0]   nq_p    [DIV_STAGES+1];
  logic [IN_W-1:0] div_p   [DIV_STAGES+1];
  logic            sign_p  [DIV_STAGES+1];
  logic            dbz_p   [DIV_STAGES+1];
  hue_fn_t         fn_p    [DIV_STAGES+1];
  logic            valid_p [DIV_STAGES+1];

  logic [IN_W-1:0] mag_a, mag_d, s0_mag_a, s0_mag_d;
  logic            s0_sign, s0_dbz, s0_valid;
  hue_fn_t         s0_fn;

  // The most negative input negates to 2^(IN_W-1), which still fits unsigned.
  assign mag_a = i_dividend[IN_W-1] ? -i_dividend : i_dividend;
  assign mag_d = i_divisor[IN_W-1]  ? -i_divisor  : i_divisor;

  always_ff @(posedge i_clk) begin
    if (i_rst) s0_valid <= 1'b0;
    else if (en) s0_valid <= i_valid;
  end

  always_ff @(posedge i_clk) begin
    if (en) begin
      s0_mag_a <= mag_a;
      s0_mag_d <= mag_d;
      s0_sign  <= i_dividend[IN_W-1] ^ i_divisor[IN_W-1];
      s0_dbz   <= (i_divisor == '0);
      s0_fn    <= hue_fn_t'(i_function);
    end
  end

  assign rem_p[0]   = '0;
  assign nq_p[0]    = {s0_mag_a, {FRAC_W{1'b0}}};
  assign div_p[0]   = s0_mag_d;
  assign sign_p[0]  = s0_sign;
  assign dbz_p[0]   = s0_dbz;
  assign fn_p[0]    = s0_fn;
  assign valid_p[0] = s0_valid;

  for (genvar k = 0; k < DIV_STAGES; k++) begin : g_stage
    hue_div_stage #(.IN_W(IN_W), .QW(QW)) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .en      (en),
      .rem     (rem_p[k]),
      .nq      (nq_p[k]),
      .div     (div_p[k]),
      .sign    (sign_p[k]),
      .dbz     (dbz_p[k]),
      .fn      (fn_p[k]),
      .valid   (valid_p[k]),
      .rem_r   (rem_p[k+1]),
      .nq_r    (nq_p[k+1]),
      .div_r   (div_p[k+1]),
      .sign_r  (sign_p[k+1]),
      .dbz_r   (dbz_p[k+1]),
      .fn_r    (fn_p[k+1]),
      .valid_r (valid_p[k+1])
    );
  end

  logic signed [SUM_W-1:0] q_s, sum, res;

  // NOTE: every always_comb output gets a default on entry so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    q_s = SUM_W'(nq_p[DIV_STAGES]);
    if (sign_p[DIV_STAGES]) q_s = -q_s;
    sum = q_s + SUM_W'(hue_offset(fn_p[DIV_STAGES], FRAC_W));
    if (fn_p[DIV_STAGES] == HUE_FN_SECT_R && sum[SUM_W-1])
      sum = sum + SUM_W'(HUE_SECT_SPAN << FRAC_W);
    res = sum;
    if (sum > SAT_MAX)      res = SAT_MAX;
    else if (sum < SAT_MIN) res = SAT_MIN;
    if (dbz_p[DIV_STAGES]) res = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_dbz   <= 1'b0;
    end else if (en) begin
      o_valid <= valid_p[DIV_STAGES];
      o_data  <= res[OUT_W-1:0];
      o_dbz   <= valid_p[DIV_STAGES] & dbz_p[DIV_STAGES];
    end
  end

  // The final remainder, divisor and saturated high bits have no consumer.
  logic unused_tail;
  assign unused_tail = ^{rem_p[DIV_STAGES], div_p[DIV_STAGES], res[SUM_W-1:OUT_W]};

endmodule

// File: tb/tb_hue_div_pipe.sv
// Self-checking bench for hue_div_pipe: vector table plus scoreboard, random
// backpressure, explicit full-pipeline stall and reset with items in flight.
module tb_hue_div_pipe;

  localparam int IN_W = 9, FRAC_W = 8, OUT_W = 16, LAT = 19;

  logic             i_clk = 1'b0;
  logic             i_rst, i_valid, i_ready, o_ready, o_dbz, o_valid;
  logic [IN_W-1:0]  i_dividend, i_divisor;
  logic [1:0]       i_function;
  logic [OUT_W-1:0] o_data;

  hue_div_pipe #(.IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dividend(i_dividend), .i_divisor(i_divisor),
    .i_function(i_function), .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data),
    .o_dbz(o_dbz), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] data;
    logic        dbz;
    int          cyc;
    logic        chk_lat;
  } exp_t;

  typedef struct {
    logic [8:0]  a;
    logic [8:0]  d;
    logic [1:0]  fn;
    logic [15:0] data;
    logic        dbz;
  } vec_t;

  exp_t sb[$];
  exp_t pend;
  int   n_cmp = 0, n_err = 0, cyc = 0;
  logic lat_mode = 1'b0, rand_rdy = 1'b0;
  logic prev_hold = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sx9(input logic [8:0] v);
    return v[8] ? int'(v) - 512 : int'(v);
  endfunction

  function automatic exp_t mk(input logic [15:0] data, input logic dbz);
    exp_t e;
    e.data = data; e.dbz = dbz; e.cyc = 0; e.chk_lat = lat_mode;
    return e;
  endfunction

  // Reference: truncating integer division, then offset, sector-R wrap, clamp.
  function automatic exp_t model(input logic [8:0] a9, input logic [8:0] d9, input logic [1:0] fn);
    int a, d, ma, md, q, s;
    a = sx9(a9); d = sx9(d9);
    if (d == 0) return mk(16'h0000, 1'b1);
    ma = (a < 0) ? -a : a;
    md = (d < 0) ? -d : d;
    q  = (ma * 256) / md;
    if ((a < 0) != (d < 0)) q = -q;
    s = q + ((fn == 2'd2) ? 512 : (fn == 2'd3) ? 1024 : 0);
    if (fn == 2'd1 && s < 0) s = s + 1536;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return mk(16'(s), 1'b0);
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    #1;
    if (rand_rdy) i_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor: all transfers are judged on the falling edge, between updates.
  always @(negedge i_clk) begin
    if (i_rst) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, prev_data);
      end
      if (!o_ready) check("ready_low_only_when_held", o_valid & ~i_ready, 1);
      if (o_valid && i_ready) begin
        if (sb.size() == 0) check("unexpected_output", o_valid, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("data", o_data, e.data);
          check("dbz", o_dbz, e.dbz);
          if (e.chk_lat) check("latency", cyc - e.cyc, LAT);
        end
      end
      if (i_valid && o_ready) begin
        exp_t e;
        e = pend;
        e.cyc = cyc;
        sb.push_back(e);
      end
      prev_hold = o_valid & ~i_ready;
      prev_data = o_data;
    end
  end

  task automatic wait_accept();
    int t = 0;
    @(negedge i_clk);
    while (!o_ready && t < 500) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_ready) check("accept_timeout", o_ready, 1);
  endtask

  task automatic send(input logic [8:0] a, input logic [8:0] d, input logic [1:0] fn, input exp_t e);
    @(posedge i_clk); #1;
    i_dividend = a; i_divisor = d; i_function = fn; i_valid = 1'b1;
    pend = e;
    wait_accept();
  endtask

  task automatic idle();
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    check("drain_remaining", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    int   quiet;
    vt[0] = '{9'h1FB, 9'h002, 2'd0, 16'hFD80, 1'b0};  // -5 / 2
    vt[1] = '{9'h001, 9'h003, 2'd0, 16'h0055, 1'b0};  // 1 / 3
    vt[2] = '{9'h000, 9'h003, 2'd2, 16'h0200, 1'b0};  // 0 / 3 + G
    vt[3] = '{9'h003, 9'h002, 2'd2, 16'h0380, 1'b0};  // 3 / 2 + G
    vt[4] = '{9'h1F6, 9'h003, 2'd1, 16'h02AB, 1'b0};  // -10 / 3, wrapped
    vt[5] = '{9'h019, 9'h000, 2'd3, 16'h0000, 1'b1};  // 25 / 0
    vt[6] = '{9'h1D6, 9'h000, 2'd1, 16'h0000, 1'b1};  // -42 / 0
    vt[7] = '{9'h100, 9'h001, 2'd0, 16'h8000, 1'b0};  // -256 / 1 saturates low
    vt[8] = '{9'h0FF, 9'h001, 2'd0, 16'h7FFF, 1'b0};  // 255 / 1 saturates high

    // Reset with i_valid high: that input must never surface.
    i_rst = 1'b1; i_ready = 1'b1; i_valid = 1'b1;
    i_dividend = 9'h007; i_divisor = 9'h001; i_function = 2'd0;
    pend = mk(16'h0700, 1'b0);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    check("reset_o_valid", o_valid, 0);
    check("reset_o_data", o_data, 0);
    check("reset_o_dbz", o_dbz, 0);
    check("reset_o_ready", o_ready, 1);

    // Single item, exact latency.
    lat_mode = 1'b1;
    send(vt[0].a, vt[0].d, vt[0].fn, mk(vt[0].data, vt[0].dbz));
    idle();
    wait_empty();

    // Back-to-back vectors; the latency check forces consecutive outputs.
    for (int i = 1; i < 9; i++) send(vt[i].a, vt[i].d, vt[i].fn, mk(vt[i].data, vt[i].dbz));
    idle();
    wait_empty();

    // Random backpressure with occasional input gaps.
    lat_mode = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [8:0] a, d;
      logic [1:0] fn;
      a  = 9'($urandom_range(0, 511));
      d  = ($urandom_range(0, 6) == 0) ? 9'h000 : 9'($urandom_range(0, 511));
      fn = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle();
      send(a, d, fn, model(a, d, fn));
    end
    idle();
    wait_empty();
    @(posedge i_clk); #1;
    rand_rdy = 1'b0; i_ready = 1'b1;

    // Full pipeline held by i_ready low: upstream must be refused.
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [8:0] a;
      a = 9'(i * 37 + 5);
      send(a, 9'h007, 2'd2, model(a, 9'h007, 2'd2));
    end
    @(posedge i_clk); #1;
    i_dividend = 9'h1C0; i_divisor = 9'h1FD; i_function = 2'd1; i_valid = 1'b1;
    pend = model(9'h1C0, 9'h1FD, 2'd1);
    repeat (25) @(negedge i_clk);
    check("stall_o_ready", o_ready, 0);
    check("stall_o_valid", o_valid, 1);
    check("stall_head_data", o_data, sb[0].data);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    wait_accept();
    idle();
    wait_empty();

    // Reset with ten items in flight: nothing may come out afterwards.
    for (int i = 0; i < 10; i++) begin
      logic [8:0] a;
      a = 9'(i * 11 + 1);
      send(a, 9'h003, 2'd0, model(a, 9'h003, 2'd0));
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_valid = 1'b0;
    quiet = 0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge i_clk);
      if (o_valid) quiet++;
    end
    check("post_reset_valid_cycles", quiet, 0);
    lat_mode = 1'b1;
    send(9'h1F6, 9'h003, 2'd1, mk(16'h02AB, 1'b0));
    idle();
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hue_div_pipe.md
# hue_div_pipe

Parametrised, fully pipelined signed fixed-point divider with hue-sector post-processing. It is the next generation of `hue_stage0`. It accepts one (dividend, divisor, function) triple per clock and returns the quotient in signed Q format, with an optional sector offset and wrap applied. It adds divide-by-zero flagging, output saturation and a global-stall valid/ready handshake. It sits between the min/max/delta stage and the hue-to-threshold compare in the color-detect path.

## Interface
- `IN_W`, default 9: two's-complement width of dividend and divisor.
- `FRAC_W`, default 8: fractional bits of the quotient and of `o_data`.
- `OUT_W`, default 16: width of `o_data`, signed Q(OUT_W-FRAC_W).FRAC_W.
- `QW` (localparam) = IN_W+FRAC_W: unsigned quotient magnitude width, 17 by default.
- `LATENCY` (localparam) = QW+2: input-to-output cycles with no stall, 19 by default.
- `i_clk`  in  1: single clock, all logic on rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_dividend`  in  IN_W: signed dividend.
- `i_divisor`  in  IN_W: signed divisor.
- `i_function`  in  2: 0 = RAW, 1 = SECT_R (+0, wrap to [0,6)), 2 = SECT_G (+2), 3 = SECT_B (+4).
- `i_valid`  in  1: input triple valid.
- `o_ready`  out  1: upstream may present data; a transfer occurs when `i_valid & o_ready`.
- `o_data`  out  OUT_W: signed fixed-point result.
- `o_dbz`  out  1: divisor was zero; qualified by `o_valid`.
- `o_valid`  out  1: output valid.
- `i_ready`  in  1: downstream accepts; a transfer occurs when `o_valid & i_ready`.

## Operation
- Stage 0 (input register): compute and register the following.
  - |dividend| and |divisor|, each IN_W bits unsigned. The most negative input maps to 2^(IN_W-1) and fits.
  - Result sign = sign(dividend) XOR sign(divisor).
  - dbz = (divisor == 0).
  - The function tag.
- Stages 1..QW: restoring division of (|dividend| << FRAC_W) by |divisor|, one quotient bit per stage, MSB first. Partial remainder, shifted numerator, sign, dbz, tag and valid travel alongside.
- Quotient magnitude truncates toward zero. Negation is applied after truncation, so -5/2 gives exactly -2.5 and -10/3 gives -(853/256).
- Stage QW+1 (output):
  - Signed quotient q is sign-extended to OUT_W+2 bits.
  - Add the tag offset: 0, 2<<FRAC_W or 4<<FRAC_W.
  - SECT_R only: if the sum is < 0, add 6<<FRAC_W.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If dbz, force `o_data` = 0 and `o_dbz` = 1; tag and offset are ignored.
- Stall: `en = ~o_valid | i_ready`, and `o_ready = en`.
  - Every pipeline register, valid bits included, advances only when `en` is 1.
  - Bubbles are not compressed. While stalled, outputs hold.
- Input not valid while `en` is 1: a bubble (valid = 0) enters stage 0. Data registers may hold don't-care values, but valid must be 0.

## Timing
- Latency is LATENCY = QW+2 cycles with no stall. Throughput is one result per clock.
- Each stall cycle adds exactly one cycle to the latency of every in-flight item.
- Reset values: `o_valid` = 0, `o_data` = 0, `o_dbz` = 0. All internal valid bits are 0.
- `o_ready` = 1 in the first cycle after reset release.
- Reset mid-operation drops every in-flight item. No output appears for items accepted before reset.
- `i_valid` in the reset cycle is ignored.
- `o_valid` and `i_ready` high together with a new `i_valid`: output, pipeline and input all advance in the same edge with no loss.
- `i_ready` held low with a full pipeline: `o_ready` = 0, `o_data` is stable, and nothing is accepted.
- Inputs must be held while `i_valid & ~o_ready`.

## Structure
- Package `hue_pkg` holds:
  - enum `hue_fn_t` (HUE_FN_RAW, HUE_FN_SECT_R, HUE_FN_SECT_G, HUE_FN_SECT_B);
  - integer sector constants 0/2/4/6;
  - a function returning the offset for a tag given FRAC_W.
- Sub-module `hue_div_stage`: one restoring step (compare, subtract, shift, quotient bit) plus its pass-through sideband register and enable. It is instantiated QW times in a generate loop.
- The top level holds the stage-0 abs/sign logic, the output offset/wrap/saturate stage and the handshake.

## Test plan
- Defaults, `i_ready` = 1: (-5, 2, RAW) -> `o_data` 0xFD80 (-2.5), `o_dbz` 0, exactly 19 cycles after acceptance.
- Back-to-back inputs, one per cycle, `i_ready` = 1:
  - (1, 3, RAW) -> 0x0055
  - (0, 3, SECT_G) -> 0x0200
  - (3, 2, SECT_G) -> 0x0380
  - (-10, 3, SECT_R) -> 0x02AB (wrapped)
  - The four results appear on four consecutive `o_valid` cycles.
- Divide by zero: (25, 0, any tag) and (-42, 0, any tag) -> `o_data` 0, `o_dbz` 1.
- Saturation: (-256, 1, RAW) -> 0x8000; (255, 1, RAW) -> 0x7FFF.
- Backpressure:
  - Stream 30 items with random `i_ready`.
  - Order and values must match the scoreboard; none lost or duplicated.
  - `o_data` stays stable while `o_valid & ~i_ready`.
  - `o_ready` falls only while the output is held.
- Reset while 10 items are in flight: assert `i_rst` for 1 cycle -> `o_valid` stays 0 for the next 19 cycles; a new item then returns normally.
